// File: rtl/imem_port_arbiter.sv
// -----------------------------------------------------------------------------
// imem_port_arbiter
//   Shares one single-port synchronous instruction ROM (registered address,
//   1-cycle read) between the IF-stage fetch port (F) and the MEM-stage data
//   port (D). At most one grant per cycle; the ROM data returned the next cycle
//   is routed to whichever port owned the previous cycle. One fetch response
//   can be parked in a buffer while the IF stage stalls.
//
//   Optional feature macro: ARB_FAIR_EN
//     defined   : starvation guard, F wins after MAX_D_STREAK consecutive D
//                 grants taken while F was waiting.
//     undefined : strict D priority, no streak counter is built.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   f_req/f_addr/f_gnt  fetch request, word address, combinational grant
//   f_rvalid/f_rdata    fetch response (valid/ready with f_rready)
//   f_rready            IF stage accepts the fetch response
//   d_req/d_addr/d_gnt  data request, word address, combinational grant
//   d_rvalid/d_rdata    data response, single-cycle pulse, no backpressure
//   mem_addr            ROM address (the ROM registers it)
//   mem_rdata           ROM data, valid one cycle after the address
// -----------------------------------------------------------------------------
module imem_port_arbiter #(
    parameter int AW           = 30,
    parameter int DW           = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [DW-1:0] f_rdata,
    input  logic          f_rready,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata
);

    // The streak counter is 4 bits wide, so the limit must fit.
    if ((MAX_D_STREAK < 1) || (MAX_D_STREAK > 15)) begin : g_bad_streak
        $error("MAX_D_STREAK must be in 1..15");
    end

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_F    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    owner_e        r_owner;
    owner_e        w_owner_nxt;
    logic          r_fbuf_full;
    logic [DW-1:0] r_fbuf;
    logic [AW-1:0] r_mem_addr_q;

    logic          w_f_elig;
    logic          w_fair_force;
    logic          w_f_gnt;
    logic          w_d_gnt;

    // F may not be granted while its previous response is still unaccepted:
    // either parked in the buffer or arriving this cycle with f_rready low.
    assign w_f_elig = f_req & ~r_fbuf_full & ~((r_owner == OWN_F) & ~f_rready);

`ifdef ARB_FAIR_EN
    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
    logic [3:0] r_streak;

    assign w_fair_force = w_f_elig & (r_streak == STREAK_MAX);

    // Count D grants taken while F waits; any F grant or F dropping out resets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_streak <= 4'd0;
        end else if (w_f_gnt || !w_f_elig) begin
            r_streak <= 4'd0;
        end else if (w_d_gnt && (r_streak != STREAK_MAX)) begin
            r_streak <= r_streak + 4'd1;
        end else begin
            r_streak <= r_streak;
        end
    end
`else
    assign w_fair_force = 1'b0;
`endif

    // Grant selection: D first unless the fairness guard hands the slot to F.
    // Grants are held off while reset is asserted.
    always_comb begin
        w_d_gnt     = 1'b0;
        w_f_gnt     = 1'b0;
        w_owner_nxt = OWN_NONE;
        if (!rst_n) begin
            w_d_gnt = 1'b0;
            w_f_gnt = 1'b0;
        end else if (d_req && !w_fair_force) begin
            w_d_gnt = 1'b1;
        end else if (w_f_elig) begin
            w_f_gnt = 1'b1;
        end else begin
            w_d_gnt = 1'b0;
            w_f_gnt = 1'b0;
        end
        if (w_d_gnt) begin
            w_owner_nxt = OWN_D;
        end else if (w_f_gnt) begin
            w_owner_nxt = OWN_F;
        end else begin
            w_owner_nxt = OWN_NONE;
        end
    end

    // ROM address mux; with no grant the last address is held so ROM data stays stable.
    always_comb begin
        mem_addr = r_mem_addr_q;
        if (w_d_gnt) begin
            mem_addr = d_addr;
        end else if (w_f_gnt) begin
            mem_addr = f_addr;
        end else begin
            mem_addr = r_mem_addr_q;
        end
    end

    // Owner of the read in flight and the last presented address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner      <= OWN_NONE;
            r_mem_addr_q <= '0;
        end else begin
            r_owner      <= w_owner_nxt;
            r_mem_addr_q <= mem_addr;
        end
    end

    // Fetch buffer: park a fetch response the IF stage did not accept, release on f_rready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fbuf_full <= 1'b0;
            r_fbuf      <= '0;
        end else if (r_fbuf_full) begin
            r_fbuf_full <= ~f_rready;
            r_fbuf      <= r_fbuf;
        end else if ((r_owner == OWN_F) && !f_rready) begin
            r_fbuf_full <= 1'b1;
            r_fbuf      <= mem_rdata;
        end else begin
            r_fbuf_full <= 1'b0;
            r_fbuf      <= r_fbuf;
        end
    end

    // Response routing; the buffered fetch is always older than any live one.
    always_comb begin
        f_rvalid = r_fbuf_full | (r_owner == OWN_F);
        f_rdata  = mem_rdata;
        if (r_fbuf_full) begin
            f_rdata = r_fbuf;
        end else begin
            f_rdata = mem_rdata;
        end
        d_rvalid = (r_owner == OWN_D);
        d_rdata  = mem_rdata;
    end

    assign f_gnt = w_f_gnt;
    assign d_gnt = w_d_gnt;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed testbench for imem_port_arbiter with a behavioural ROM.
module tb_imem_port_arbiter;

    localparam int AW = 30;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt;
    logic          f_rvalid;
    logic [DW-1:0] f_rdata;
    logic          f_rready;
    logic          d_req;
    logic [AW-1:0] d_addr;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;

    int n_cmp;
    int n_bad;

    imem_port_arbiter #(.AW(AW), .DW(DW), .MAX_D_STREAK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_gnt     (f_gnt),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .f_rready  (f_rready),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: word 0 holds a fixed instruction, others are 0xA5000000 ^ addr.
    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        if (a == 30'd0) return 32'h3c1d1000;
        return 32'hA500_0000 ^ {2'b00, a};
    endfunction

    // Synchronous ROM: registered address, one-cycle read.
    always_ff @(posedge clk) mem_rdata <= rom_word(mem_addr);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        f_req    = 1'b1;
        d_req    = 1'b1;
        f_addr   = 30'h5;
        d_addr   = 30'h9;
        f_rready = 1'b1;

        // 1: reset holds everything off, then a single fetch.
        tick();
        settle();
        check_eq("rst_f_gnt",    {31'd0, f_gnt},    32'd0);
        check_eq("rst_d_gnt",    {31'd0, d_gnt},    32'd0);
        check_eq("rst_f_rvalid", {31'd0, f_rvalid}, 32'd0);
        check_eq("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        check_eq("rst_mem_addr", {2'b00, mem_addr}, 32'd0);
        rst_n = 1'b1;
        d_req = 1'b0;
        settle();
        check_eq("t1_f_gnt",    {31'd0, f_gnt},    32'd1);
        check_eq("t1_mem_addr", {2'b00, mem_addr}, 32'h5);
        tick();
        f_req = 1'b0;
        settle();
        check_eq("t1_f_rvalid", {31'd0, f_rvalid}, 32'd1);
        check_eq("t1_f_rdata",  f_rdata,           32'hA500_0005);
        check_eq("t1_d_rvalid", {31'd0, d_rvalid}, 32'd0);

        // 2: simultaneous requests, D first, then F.
        f_req  = 1'b1;
        f_addr = 30'h10;
        d_req  = 1'b1;
        d_addr = 30'h20;
        settle();
        check_eq("t2_d_gnt",    {31'd0, d_gnt},    32'd1);
        check_eq("t2_f_gnt",    {31'd0, f_gnt},    32'd0);
        check_eq("t2_mem_addr", {2'b00, mem_addr}, 32'h20);
        tick();
        d_req = 1'b0;
        settle();
        check_eq("t2_d_rvalid",  {31'd0, d_rvalid}, 32'd1);
        check_eq("t2_d_rdata",   d_rdata,           32'hA500_0020);
        check_eq("t2_f_rvalid0", {31'd0, f_rvalid}, 32'd0);
        check_eq("t2_f_gnt2",    {31'd0, f_gnt},    32'd1);
        check_eq("t2_mem_addr2", {2'b00, mem_addr}, 32'h10);
        tick();
        f_req = 1'b0;
        settle();
        check_eq("t2_f_rvalid", {31'd0, f_rvalid}, 32'd1);
        check_eq("t2_f_rdata",  f_rdata,           32'hA500_0010);
        check_eq("t2_d_rvalid0", {31'd0, d_rvalid}, 32'd0);
        tick();

        // 3: stalled fetch parks in the buffer and blocks further fetch grants.
        f_req  = 1'b1;
        f_addr = 30'h0;
        settle();
        check_eq("t3_f_gnt", {31'd0, f_gnt}, 32'd1);
        tick();
        f_addr   = 30'h1;
        f_rready = 1'b0;
        settle();
        check_eq("t3_f_rvalid_a", {31'd0, f_rvalid}, 32'd1);
        check_eq("t3_f_rdata_a",  f_rdata,           32'h3c1d1000);
        check_eq("t3_f_gnt_a",    {31'd0, f_gnt},    32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t3_stall_rvalid", {31'd0, f_rvalid}, 32'd1);
            check_eq("t3_stall_rdata",  f_rdata,           32'h3c1d1000);
            check_eq("t3_stall_gnt",    {31'd0, f_gnt},    32'd0);
        end
        f_rready = 1'b1;
        settle();
        check_eq("t3_drain_rdata", f_rdata,        32'h3c1d1000);
        check_eq("t3_drain_gnt",   {31'd0, f_gnt}, 32'd0);
        tick();
        check_eq("t3_post_rvalid", {31'd0, f_rvalid}, 32'd0);
        check_eq("t3_post_gnt",    {31'd0, f_gnt},    32'd1);
        check_eq("t3_post_addr",   {2'b00, mem_addr}, 32'h1);
        tick();
        f_req = 1'b0;
        settle();
        check_eq("t3_next_rvalid", {31'd0, f_rvalid}, 32'd1);
        check_eq("t3_next_rdata",  f_rdata,           32'hA500_0001);

        // 4: both requesters held high.
        f_req  = 1'b1;
        d_req  = 1'b1;
        f_addr = 30'h2;
        d_addr = 30'h3;
        for (int i = 0; i < 10; i++) begin
            logic exp_f;
`ifdef ARB_FAIR_EN
            exp_f = ((i % 5) == 4);
`else
            exp_f = 1'b0;
`endif
            settle();
            check_eq("t4_f_gnt", {31'd0, f_gnt}, {31'd0, exp_f});
            check_eq("t4_d_gnt", {31'd0, d_gnt}, {31'd0, ~exp_f});
            tick();
        end
        f_req = 1'b0;
        d_req = 1'b0;
        tick();
        tick();

        // 5: reset right after a D grant discards the response.
        d_req  = 1'b1;
        d_addr = 30'h3;
        settle();
        check_eq("t5_d_gnt", {31'd0, d_gnt}, 32'd1);
        tick();
        rst_n = 1'b0;
        d_req = 1'b0;
        settle();
        check_eq("t5_rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        check_eq("t5_rst_mem_addr", {2'b00, mem_addr}, 32'd0);
        tick();
        rst_n = 1'b1;
        settle();
        check_eq("t5_rel_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        check_eq("t5_rel_f_rvalid", {31'd0, f_rvalid}, 32'd0);
        check_eq("t5_rel_mem_addr", {2'b00, mem_addr}, 32'd0);
        tick();
        check_eq("t5_post_d_rvalid", {31'd0, d_rvalid}, 32'd0);

        // 6: address held across idle cycles.
        f_req  = 1'b1;
        f_addr = 30'h7;
        settle();
        check_eq("t6_f_gnt", {31'd0, f_gnt}, 32'd1);
        tick();
        f_req = 1'b0;
        settle();
        check_eq("t6_f_rdata", f_rdata, 32'hA500_0007);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("t6_idle_addr",     {2'b00, mem_addr}, 32'h7);
            check_eq("t6_idle_f_rvalid", {31'd0, f_rvalid}, 32'd0);
            check_eq("t6_idle_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
